be_clock_ctrl: RTL and testbench
================================

Name: be_clock_ctrl

Overview:
Sequencer for the computer's system clock. It generates the CPU clock pair (oCLK, oNOT_CLK) from the FPGA clock in continuous, single-step and N-cycle burst modes, with a selectable divisor and CPU halt handling. Every mode starts and stops only on whole periods, so the high phase is never truncated. The outputs feed all CPU modules; the control inputs come from board switches, buttons and the control-word HLT line.

Parameters:
BASE_DIV, 25000000, half-period in iCLK cycles for iDIV_SEL=0 (1 Hz at 50 MHz)
DEBOUNCE_CYCLES, 500000, stable-sample count for the step button (only with debounce macro)
CNT_W, 26, width of the half-period and debounce counters

Ports:
iCLK  in  1  FPGA board clock; the only clock
iRST  in  1  synchronous, active-high reset
iCONT  in  1  level; 1 = continuous run requested
iSTEP_BTN  in  1  raw step push button, active high, asynchronous
iBURST_GO  in  1  one-cycle pulse; start burst
iBURST_LEN  in  8  number of periods for a burst
iDIV_SEL  in  3  divisor select
iHLT  in  1  CPU halt request, active high
iRESUME  in  1  one-cycle pulse; leave HALTED
oCLK  out  1  CPU clock
oNOT_CLK  out  1  always the inverse of oCLK
oTICK  out  1  one-cycle pulse on the cycle oCLK rises
oSTATE  out  3  IDLE=0, RUN=1, STEP=2, BURST=3, HALTED=4
oBURST_REM  out  8  periods remaining in the burst
oHALTED  out  1  1 while in HALTED

Behaviour:
- Clock and reset: one clock, iCLK; reset iRST is synchronous and active-high.
- Reset values: oCLK=0, oNOT_CLK=1, oTICK=0, oSTATE=IDLE, oBURST_REM=0, oHALTED=0. All counters and the step synchroniser/debouncer are cleared.
- Reset mid-period: the next edge forces the reset values; no completion of the current phase.
- Half-period H = max(1, BASE_DIV >> iDIV_SEL), computed in CNT_W bits. H is latched at each period start. A change of iDIV_SEL mid-period takes effect at the next period.
- Period start: on the edge where a start or continue decision is made, oCLK<=1, oTICK<=1, counter<=0. oCLK is high for exactly H cycles, then low for exactly H cycles. The period boundary is the last low cycle.
- Step input: iSTEP_BTN passes through a 2-flop synchroniser and an edge detector. step_evt is one cycle on the (qualified) rising edge.
- IDLE: oCLK=0. Priority on each cycle:
  1. iHLT → HALTED.
  2. iCONT → RUN.
  3. iBURST_GO with iBURST_LEN≠0 → BURST, with oBURST_REM<=iBURST_LEN.
  4. step_evt → STEP.
  - iBURST_GO with LEN=0 is ignored.
  - Entering RUN, STEP or BURST starts a period on the same edge.
- RUN: at each boundary:
  - iHLT → HALTED;
  - else iCONT=0 → IDLE;
  - else start the next period.
- STEP: one period, then at the boundary → IDLE, or HALTED if iHLT=1.
- BURST: oBURST_REM decrements at each boundary. When it reaches 0 → IDLE, or HALTED if iHLT=1. iHLT at an earlier boundary → HALTED, and oBURST_REM holds its value.
- iCONT, iBURST_GO and step_evt while not IDLE are ignored. iHLT is only sampled at boundaries or in IDLE.
- HALTED: oCLK=0, oHALTED=1. iRESUME with iHLT=0 → IDLE, oBURST_REM<=0. iRESUME while iHLT=1 is ignored.
- oNOT_CLK is a registered inverse of oCLK in the same cycle (never equal to oCLK).

Optional Feature:
BE_CLK_DEBOUNCE_EN:
- Defined: the synchronised button must hold a new level for DEBOUNCE_CYCLES consecutive cycles before the debounced level changes. step_evt fires on the debounced rising edge; latency is sync + DEBOUNCE_CYCLES.
- Undefined: step_evt fires on the synchronised rising edge directly; the debouncer logic is absent.

Test Plan:
Bench parameters: BASE_DIV=8, DEBOUNCE_CYCLES=4.
1. Reset, iDIV_SEL=0, iCONT=1 → oCLK 8 cycles high / 8 low repeating, oTICK every 16 cycles, oSTATE=1. iCONT=0 mid-high → current period completes, then oSTATE=0, oCLK=0.
2. iDIV_SEL=3 → H=1, oCLK toggles every cycle. iDIV_SEL=5 → clamped H=1. Change 0→1 mid-period → current period keeps 8/8, next is 4/4.
3. With macro: button held high 6 cycles → exactly one 8/8 period, then IDLE. Button toggled every 2 cycles → no period. Without macro: a single clean press → one period.
4. iBURST_LEN=3, iBURST_GO → exactly 3 oTICKs, oBURST_REM 3→2→1→0, then IDLE. iBURST_LEN=0 with iBURST_GO → stays IDLE, oCLK stays 0.
5. RUN, iHLT=1 at cycle 3 of the high phase → period completes (8 high, 8 low), then oSTATE=4, oHALTED=1, oCLK=0. iRESUME with iHLT=1 → stays HALTED. iHLT=0 then iRESUME → IDLE.
6. iRST pulsed at cycle 4 of the high phase in BURST → next cycle oCLK=0, oNOT_CLK=1, oSTATE=0, oBURST_REM=0.

Source files
------------

// File: rtl/be_clock_ctrl.sv
// CPU clock sequencer: continuous, single-step and N-period burst modes with whole-period start/stop.
// Optional step-button debouncer enabled by defining BE_CLK_DEBOUNCE_EN.
module be_clock_ctrl #(
    parameter int unsigned BASE_DIV        = 25000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iCONT,
    input  logic       iSTEP_BTN,
    input  logic       iBURST_GO,
    input  logic [7:0] iBURST_LEN,
    input  logic [2:0] iDIV_SEL,
    input  logic       iHLT,
    input  logic       iRESUME,
    output logic       oCLK,
    output logic       oNOT_CLK,
    output logic       oTICK,
    output logic [2:0] oSTATE,
    output logic [7:0] oBURST_REM,
    output logic       oHALTED
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_BURST  = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] BASE_H = CNT_W'(BASE_DIV);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state, state_n;
    logic             clk_q, clk_n;
    logic             not_clk_q;
    logic             tick_q, tick_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] h_lat, h_n;
    logic [7:0]       burst_rem, rem_n;
    logic [CNT_W-1:0] h_shift, h_sel;
    logic             half_done, start;

    logic step_s1, step_s2, step_lvl, step_lvl_q, step_evt;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            step_s1    <= 1'b0;
            step_s2    <= 1'b0;
            step_lvl_q <= 1'b0;
        end else begin
            step_s1    <= iSTEP_BTN;
            step_s2    <= step_s1;
            step_lvl_q <= step_lvl;
        end
    end

`ifdef BE_CLK_DEBOUNCE_EN
    logic [CNT_W-1:0] db_cnt;

    // Level only flips after DEBOUNCE_CYCLES consecutive samples disagreeing with it.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            step_lvl <= 1'b0;
            db_cnt   <= '0;
        end else if (step_s2 == step_lvl) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            step_lvl <= step_s2;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + ONE;
        end
    end
`else
    always_comb step_lvl = step_s2;
`endif

    assign step_evt = step_lvl & ~step_lvl_q;

    always_comb begin
        h_shift = BASE_H >> iDIV_SEL;
        h_sel   = (h_shift == '0) ? ONE : h_shift;
    end

    // cnt counts within the current half-period; clk_q tells which half we are in.
    always_comb begin
        state_n   = state;
        clk_n     = clk_q;
        tick_n    = 1'b0;
        cnt_n     = cnt;
        h_n       = h_lat;
        rem_n     = burst_rem;
        start     = 1'b0;
        half_done = (cnt == h_lat - ONE);

        case (state)
            S_IDLE: begin
                clk_n = 1'b0;
                if (iHLT) begin
                    state_n = S_HALTED;
                end else if (iCONT) begin
                    state_n = S_RUN;
                    start   = 1'b1;
                end else if (iBURST_GO && (iBURST_LEN != '0)) begin
                    state_n = S_BURST;
                    rem_n   = iBURST_LEN;
                    start   = 1'b1;
                end else if (step_evt) begin
                    state_n = S_STEP;
                    start   = 1'b1;
                end
            end
            S_RUN, S_STEP, S_BURST: begin
                if (!half_done) begin
                    cnt_n = cnt + ONE;
                end else if (clk_q) begin
                    clk_n = 1'b0;
                    cnt_n = '0;
                end else begin
                    cnt_n = '0;
                    case (state)
                        S_RUN: begin
                            if (iHLT)        state_n = S_HALTED;
                            else if (!iCONT) state_n = S_IDLE;
                            else             start   = 1'b1;
                        end
                        S_STEP: begin
                            state_n = iHLT ? S_HALTED : S_IDLE;
                        end
                        default: begin
                            rem_n = burst_rem - 8'd1;
                            if (iHLT)                    state_n = S_HALTED;
                            else if (burst_rem == 8'd1)  state_n = S_IDLE;
                            else                         start   = 1'b1;
                        end
                    endcase
                end
            end
            S_HALTED: begin
                clk_n = 1'b0;
                if (iRESUME && !iHLT) begin
                    state_n = S_IDLE;
                    rem_n   = '0;
                end
            end
            default: begin
                state_n = S_IDLE;
                clk_n   = 1'b0;
            end
        endcase

        if (start) begin
            clk_n  = 1'b1;
            tick_n = 1'b1;
            cnt_n  = '0;
            h_n    = h_sel;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state     <= S_IDLE;
            clk_q     <= 1'b0;
            not_clk_q <= 1'b1;
            tick_q    <= 1'b0;
            cnt       <= '0;
            h_lat     <= ONE;
            burst_rem <= '0;
        end else begin
            state     <= state_n;
            clk_q     <= clk_n;
            not_clk_q <= ~clk_n;
            tick_q    <= tick_n;
            cnt       <= cnt_n;
            h_lat     <= h_n;
            burst_rem <= rem_n;
        end
    end

    assign oCLK       = clk_q;
    assign oNOT_CLK   = not_clk_q;
    assign oTICK      = tick_q;
    assign oSTATE     = state;
    assign oBURST_REM = burst_rem;
    assign oHALTED    = (state == S_HALTED);

endmodule

// File: tb/tb_be_clock_ctrl.sv
// Self-checking bench for be_clock_ctrl (BASE_DIV=8, DEBOUNCE_CYCLES=4): per-cycle expectation queue.
module tb_be_clock_ctrl;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_STEP  = 3'd2;
    localparam logic [2:0] ST_BURST = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    logic       iCLK = 1'b0;
    logic       iRST, iCONT, iSTEP_BTN, iBURST_GO, iHLT, iRESUME;
    logic [7:0] iBURST_LEN;
    logic [2:0] iDIV_SEL;
    logic       oCLK, oNOT_CLK, oTICK, oHALTED;
    logic [2:0] oSTATE;
    logic [7:0] oBURST_REM;

    be_clock_ctrl #(
        .BASE_DIV       (8),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (26)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iCONT     (iCONT),
        .iSTEP_BTN (iSTEP_BTN),
        .iBURST_GO (iBURST_GO),
        .iBURST_LEN(iBURST_LEN),
        .iDIV_SEL  (iDIV_SEL),
        .iHLT      (iHLT),
        .iRESUME   (iRESUME),
        .oCLK      (oCLK),
        .oNOT_CLK  (oNOT_CLK),
        .oTICK     (oTICK),
        .oSTATE    (oSTATE),
        .oBURST_REM(oBURST_REM),
        .oHALTED   (oHALTED)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic       clk;
        logic       tick;
        logic [2:0] st;
        logic [7:0] rem;
    } exp_t;

    typedef struct {
        logic [2:0]  div;
        int unsigned n;
        int unsigned h;
    } div_vec_t;

    exp_t     exp_q[$];
    div_vec_t tbl[7];
    int       n_cmp = 0;
    int       n_bad = 0;
    string    tag = "init";

    task automatic push(input logic c, input logic t, input logic [2:0] s,
                        input logic [7:0] r, input int unsigned n);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.clk  = c;
            e.tick = t;
            e.st   = s;
            e.rem  = r;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_period(input int unsigned h, input logic [2:0] s, input logic [7:0] r);
        push(1'b1, 1'b1, s, r, 1);
        push(1'b1, 1'b0, s, r, h - 1);
        push(1'b0, 1'b0, s, r, h);
    endtask

    task automatic cyc();
        exp_t        e;
        logic [14:0] got, want;
        @(posedge iCLK);
        #1;
        if (exp_q.size() != 0) begin
            e    = exp_q.pop_front();
            want = {e.clk, ~e.clk, e.tick, e.st, e.rem, (e.st == ST_HALT)};
            got  = {oCLK, oNOT_CLK, oTICK, oSTATE, oBURST_REM, oHALTED};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s @%0t: got clk=%b nclk=%b tick=%b st=%0d rem=%0d halt=%b, want clk=%b nclk=%b tick=%b st=%0d rem=%0d halt=%b",
                         tag, $time, oCLK, oNOT_CLK, oTICK, oSTATE, oBURST_REM, oHALTED,
                         e.clk, ~e.clk, e.tick, e.st, e.rem, (e.st == ST_HALT));
            end
        end
    endtask

    task automatic drain();
        while (exp_q.size() != 0) cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{div: 3'd3, n: 3, h: 1};
        tbl[1] = '{div: 3'd5, n: 2, h: 1};
        tbl[2] = '{div: 3'd2, n: 2, h: 2};
        tbl[3] = '{div: 3'd4, n: 1, h: 1};
        tbl[4] = '{div: 3'd1, n: 1, h: 4};
        tbl[5] = '{div: 3'd7, n: 2, h: 1};
        tbl[6] = '{div: 3'd0, n: 1, h: 8};

        iRST = 1'b1; iCONT = 1'b0; iSTEP_BTN = 1'b0; iBURST_GO = 1'b0;
        iBURST_LEN = 8'd0; iDIV_SEL = 3'd0; iHLT = 1'b0; iRESUME = 1'b0;

        tag = "reset";
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 2); drain();
        iRST = 1'b0;
        tag = "idle_quiet";
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 2); drain();

        // Continuous run, then drop iCONT three cycles into a high phase
        tag = "run_8_8";
        iCONT = 1'b1;
        push_period(8, ST_RUN, 8'd0);
        push_period(8, ST_RUN, 8'd0);
        push(1'b1, 1'b1, ST_RUN, 8'd0, 1);
        push(1'b1, 1'b0, ST_RUN, 8'd0, 2);
        drain();
        tag = "run_stop";
        iCONT = 1'b0;
        push(1'b1, 1'b0, ST_RUN, 8'd0, 5);
        push(1'b0, 1'b0, ST_RUN, 8'd0, 8);
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 3);
        drain();

        // Divisor table, each change landing on a period boundary
        tag = "div_table";
        iCONT = 1'b1;
        for (int unsigned i = 0; i < 7; i++) begin
            iDIV_SEL = tbl[i].div;
            for (int unsigned p = 0; p < tbl[i].n; p++) push_period(tbl[i].h, ST_RUN, 8'd0);
            drain();
        end
        tag = "div_mid_change";
        push(1'b1, 1'b1, ST_RUN, 8'd0, 1);
        push(1'b1, 1'b0, ST_RUN, 8'd0, 2);
        drain();
        iDIV_SEL = 3'd1;
        push(1'b1, 1'b0, ST_RUN, 8'd0, 5);
        push(1'b0, 1'b0, ST_RUN, 8'd0, 8);
        push_period(4, ST_RUN, 8'd0);
        push_period(4, ST_RUN, 8'd0);
        drain();
        iCONT = 1'b0;
        iDIV_SEL = 3'd0;
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 2);
        drain();

`ifdef BE_CLK_DEBOUNCE_EN
        tag = "step_db_hold";
        iSTEP_BTN = 1'b1;
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 6); drain();
        iSTEP_BTN = 1'b0;
        push_period(8, ST_STEP, 8'd0);
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 4);
        drain();
        tag = "step_db_bounce";
        for (int unsigned i = 0; i < 24; i++) begin
            iSTEP_BTN = (((i / 2) % 2) == 0);
            push(1'b0, 1'b0, ST_IDLE, 8'd0, 1);
            drain();
        end
        iSTEP_BTN = 1'b0;
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 8); drain();
`else
        tag = "step_press";
        iSTEP_BTN = 1'b1;
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 2); drain();
        push_period(8, ST_STEP, 8'd0);
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 3);
        drain();
        tag = "step_release";
        iSTEP_BTN = 1'b0;
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 4); drain();
`endif

        tag = "burst3";
        iBURST_LEN = 8'd3;
        iBURST_GO  = 1'b1;
        push(1'b1, 1'b1, ST_BURST, 8'd3, 1); drain();
        iBURST_GO = 1'b0;
        push(1'b1, 1'b0, ST_BURST, 8'd3, 7);
        push(1'b0, 1'b0, ST_BURST, 8'd3, 8);
        push_period(8, ST_BURST, 8'd2);
        push_period(8, ST_BURST, 8'd1);
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 3);
        drain();

        tag = "burst0";
        iBURST_LEN = 8'd0;
        iBURST_GO  = 1'b1;
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 1); drain();
        iBURST_GO = 1'b0;
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 3); drain();

        tag = "burst1_div2";
        iDIV_SEL   = 3'd2;
        iBURST_LEN = 8'd1;
        iBURST_GO  = 1'b1;
        push(1'b1, 1'b1, ST_BURST, 8'd1, 1); drain();
        iBURST_GO = 1'b0;
        push(1'b1, 1'b0, ST_BURST, 8'd1, 1);
        push(1'b0, 1'b0, ST_BURST, 8'd1, 2);
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 2);
        drain();
        iDIV_SEL = 3'd0;

        // Halt requested mid-high: period completes before HALTED
        tag = "halt_run";
        iCONT = 1'b1;
        push(1'b1, 1'b1, ST_RUN, 8'd0, 1);
        push(1'b1, 1'b0, ST_RUN, 8'd0, 2);
        drain();
        iHLT = 1'b1;
        push(1'b1, 1'b0, ST_RUN, 8'd0, 5);
        push(1'b0, 1'b0, ST_RUN, 8'd0, 8);
        push(1'b0, 1'b0, ST_HALT, 8'd0, 3);
        drain();

        tag = "resume_blocked";
        iRESUME = 1'b1;
        push(1'b0, 1'b0, ST_HALT, 8'd0, 1); drain();
        iRESUME = 1'b0;
        push(1'b0, 1'b0, ST_HALT, 8'd0, 2); drain();

        tag = "resume";
        iHLT  = 1'b0;
        iCONT = 1'b0;
        push(1'b0, 1'b0, ST_HALT, 8'd0, 1); drain();
        iRESUME = 1'b1;
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 1); drain();
        iRESUME = 1'b0;
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 2); drain();

        tag = "idle_hlt_priority";
        iHLT  = 1'b1;
        iCONT = 1'b1;
        push(1'b0, 1'b0, ST_HALT, 8'd0, 2); drain();
        iHLT    = 1'b0;
        iCONT   = 1'b0;
        iRESUME = 1'b1;
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 1); drain();
        iRESUME = 1'b0;

        tag = "rst_mid_burst";
        iBURST_LEN = 8'd5;
        iBURST_GO  = 1'b1;
        push(1'b1, 1'b1, ST_BURST, 8'd5, 1); drain();
        iBURST_GO = 1'b0;
        push(1'b1, 1'b0, ST_BURST, 8'd5, 3); drain();
        iRST = 1'b1;
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 1); drain();
        iRST = 1'b0;
        push(1'b0, 1'b0, ST_IDLE, 8'd0, 3); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
